vm2002_change_dispenser: RTL and testbench
==========================================

// Module: vm2002_change_dispenser
// PURPOSE
// - Downstream of vm2002 core: takes the balance owed after a purchase or cancel and returns it as coins.
// - Pays out QUARTER/DIME/NICKEL one coin at a time over a req/ack handshake to the coin hopper.
// - Tracks per-denomination hopper inventory; supplier mode refills it.
// - Flags unpayable or malformed balances and hopper timeouts.
// PARAMETERS
// - AMT_W       8   width of balance/remaining, in cents (multiples of 5)
// - INV_W       8   width of each inventory counter
// - QTR_INIT    20  quarters loaded at hard reset
// - DIME_INIT   20  dimes loaded at hard reset
// - NKL_INIT    20  nickels loaded at hard reset
// - ACK_TMO     15  cycles coin_req may stay unacknowledged before error
// PORTS
// - clk           in   1      clock
// - hrst          in   1      hard reset, asynchronous, active-low
// - srst          in   1      soft reset, synchronous, active-high; aborts payout
// - balance_valid in   1      balance offered by core
// - balance       in   AMT_W  amount owed, cents
// - bal_ready     out  1      dispenser can accept a balance
// - coin_req      out  1      request hopper to eject coin_out
// - coin_out      out  2      coins_t denomination being ejected
// - coin_ack      in   1      hopper ejected the coin
// - reload        in   1      supplier refill strobe
// - reload_coin   in   2      coins_t denomination to refill
// - reload_count  in   INV_W  coins added
// - change_done   out  1      1-cycle pulse: full balance paid
// - change_err    out  1      1-cycle pulse: payout aborted
// - remaining     out  AMT_W  amount still owed
// - low_change    out  1      any inventory counter == 0
// BEHAVIOUR
// - hrst low: state=IDLE, remaining=0, coin_req=0, coin_out=NONE, done/err=0;
//   inventories = *_INIT. bal_ready=1 after release.
// - srst: next edge -> IDLE, remaining=0, coin_req=0; inventory kept. hrst has priority.
// - IDLE: bal_ready=1. Accept on balance_valid&bal_ready; latch remaining=balance.
//   balance%5!=0 -> ERR. balance==0 -> DONE. Else -> SELECT.
// - SELECT (1 cycle): greedy pick, largest first: QUARTER(25), DIME(10), NICKEL(5).
//   A coin qualifies only if value<=remaining and its inventory>0.
//   Pick registered into coin_out. None qualifies -> ERR.
// - REQ: coin_req=1, coin_out stable until coin_ack.
//   On coin_ack: remaining -= value, that inventory -= 1, coin_req drops.
//   remaining==0 -> DONE, else -> SELECT.
//   ACK_TMO cycles with no ack -> ERR; remaining and inventory unchanged.
// - DONE: change_done=1 for one cycle -> IDLE.
// - ERR: change_err=1 for one cycle -> IDLE. remaining holds unpaid amount until next accept.
// - Latency: accept at edge N; coin_req=1 from edge N+2. Minimum 2 cycles per coin after ack.
// - Greedy has no backtracking. Example: 30 with Q>0, D=0, N=0 -> ERR, remaining=5.
// - coin_ack while coin_req=0: ignored.
// - balance_valid outside IDLE: ignored; core holds it.
// - reload: honoured only in IDLE. Counter saturates at 2^INV_W-1.
//   reload_coin=NONE and reload outside IDLE are ignored.
// - bal_ready=0 in all states except IDLE. All outputs registered except low_change.
// STRUCTURE
// - vm2002_common_pkg:
//   - coins_t {NONE=0, NICKEL=1, DIME=2, QUARTER=3}
//   - VAL_NICKEL/VAL_DIME/VAL_QUARTER
//   - chg_state_t {IDLE, SELECT, REQ, DONE, ERR}
// - Sub-module vm2002_coin_inventory: three saturating counters with reload/decrement ports,
//   per-denomination nonzero flags, low_change.
// TESTING
// - Inventory full, balance=40 -> QUARTER, DIME, NICKEL acked; done; remaining=0; each inv -1.
// - Quarters=0, balance=30 -> DIME x3; done; dime inv -3.
// - Nickels=0, balance=5 -> change_err, no coin_req, remaining=5.
// - balance=37 -> change_err 1 cycle after accept, coin_req never asserted.
// - balance=25, coin_ack held low -> change_err after ACK_TMO; quarter inv unchanged.
// - srst after first ack of balance=40:
//   IDLE next edge, remaining=0, quarter inv -1 kept. reload while busy ignored.

Source files
------------

// File: rtl/vm2002_common_pkg.sv
// rtl/vm2002_common_pkg.sv - coin and change-state types shared by the vm2002 change path
package vm2002_common_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        NICKEL  = 2'd1,
        DIME    = 2'd2,
        QUARTER = 2'd3
    } coins_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        DONE,
        ERR
    } chg_state_t;

    localparam int VAL_NICKEL  = 5;
    localparam int VAL_DIME    = 10;
    localparam int VAL_QUARTER = 25;

    function automatic int coin_value(input coins_t c);
        case (c)
            NICKEL:  return VAL_NICKEL;
            DIME:    return VAL_DIME;
            QUARTER: return VAL_QUARTER;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vm2002_coin_inventory.sv
// rtl/vm2002_coin_inventory.sv - per-denomination hopper counters with saturating refill
module vm2002_coin_inventory
    import vm2002_common_pkg::*;
#(
    parameter int INV_W     = 8,
    parameter int QTR_INIT  = 20,
    parameter int DIME_INIT = 20,
    parameter int NKL_INIT  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_reload,
    input  coins_t           i_reload_coin,
    input  logic [INV_W-1:0] i_reload_count,
    input  logic             i_dec,
    input  coins_t           i_dec_coin,
    output logic             o_qtr_nz,
    output logic             o_dime_nz,
    output logic             o_nkl_nz,
    output logic             o_low_change
);

    logic [INV_W-1:0] r_qtr;
    logic [INV_W-1:0] r_dime;
    logic [INV_W-1:0] r_nkl;

    function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a, input logic [INV_W-1:0] b);
        logic [INV_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[INV_W] ? '1 : s[INV_W-1:0];
    endfunction

    assign o_qtr_nz     = (r_qtr  != '0);
    assign o_dime_nz    = (r_dime != '0);
    assign o_nkl_nz     = (r_nkl  != '0);
    assign o_low_change = !(o_qtr_nz && o_dime_nz && o_nkl_nz);

    // Refill and payout never overlap: refills are only passed through while the dispenser is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qtr  <= INV_W'(QTR_INIT);
            r_dime <= INV_W'(DIME_INIT);
            r_nkl  <= INV_W'(NKL_INIT);
        end else begin
            if (i_reload && i_reload_coin == QUARTER)
                r_qtr <= sat_add(r_qtr, i_reload_count);
            else if (i_dec && i_dec_coin == QUARTER && o_qtr_nz)
                r_qtr <= r_qtr - INV_W'(1);

            if (i_reload && i_reload_coin == DIME)
                r_dime <= sat_add(r_dime, i_reload_count);
            else if (i_dec && i_dec_coin == DIME && o_dime_nz)
                r_dime <= r_dime - INV_W'(1);

            if (i_reload && i_reload_coin == NICKEL)
                r_nkl <= sat_add(r_nkl, i_reload_count);
            else if (i_dec && i_dec_coin == NICKEL && o_nkl_nz)
                r_nkl <= r_nkl - INV_W'(1);
        end
    end

endmodule

// File: rtl/vm2002_change_dispenser.sv
// rtl/vm2002_change_dispenser.sv - greedy coin payout of an owed balance over a hopper req/ack handshake
module vm2002_change_dispenser
    import vm2002_common_pkg::*;
#(
    parameter int AMT_W     = 8,
    parameter int INV_W     = 8,
    parameter int QTR_INIT  = 20,
    parameter int DIME_INIT = 20,
    parameter int NKL_INIT  = 20,
    parameter int ACK_TMO   = 15
) (
    input  logic             clk,
    input  logic             hrst,
    input  logic             srst,
    input  logic             balance_valid,
    input  logic [AMT_W-1:0] balance,
    output logic             bal_ready,
    output logic             coin_req,
    output coins_t           coin_out,
    input  logic             coin_ack,
    input  logic             reload,
    input  coins_t           reload_coin,
    input  logic [INV_W-1:0] reload_count,
    output logic             change_done,
    output logic             change_err,
    output logic [AMT_W-1:0] remaining,
    output logic             low_change
);

    localparam int TMO_W = $clog2(ACK_TMO + 1);

    chg_state_t       r_state;
    chg_state_t       w_next_state;
    logic [AMT_W-1:0] r_remaining;
    logic [TMO_W-1:0] r_tmo;
    logic             r_coin_req;
    coins_t           r_coin_out;
    coins_t           w_pick;
    logic             r_done;
    logic             r_err;
    logic             r_bal_ready;
    logic             w_accept;
    logic             w_ack;
    logic             w_reload;
    logic [AMT_W-1:0] w_value;
    logic             w_qtr_nz;
    logic             w_dime_nz;
    logic             w_nkl_nz;

    assign w_accept = (r_state == IDLE) && r_bal_ready && balance_valid;
    assign w_ack    = (r_state == REQ) && r_coin_req && coin_ack;
    assign w_reload = reload && (r_state == IDLE) && (reload_coin != NONE);
    assign w_value  = AMT_W'(coin_value(r_coin_out));

    vm2002_coin_inventory #(
        .INV_W     (INV_W),
        .QTR_INIT  (QTR_INIT),
        .DIME_INIT (DIME_INIT),
        .NKL_INIT  (NKL_INIT)
    ) u_inv (
        .clk            (clk),
        .rst_n          (hrst),
        .i_reload       (w_reload),
        .i_reload_coin  (reload_coin),
        .i_reload_count (reload_count),
        .i_dec          (w_ack),
        .i_dec_coin     (r_coin_out),
        .o_qtr_nz       (w_qtr_nz),
        .o_dime_nz      (w_dime_nz),
        .o_nkl_nz       (w_nkl_nz),
        .o_low_change   (low_change)
    );

    always_comb begin
        w_next_state = r_state;
        w_pick       = NONE;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (balance % AMT_W'(5) != '0)
                        w_next_state = ERR;
                    else if (balance == '0)
                        w_next_state = DONE;
                    else
                        w_next_state = SELECT;
                end
            end
            SELECT: begin
                if (r_remaining >= AMT_W'(VAL_QUARTER) && w_qtr_nz)
                    w_pick = QUARTER;
                else if (r_remaining >= AMT_W'(VAL_DIME) && w_dime_nz)
                    w_pick = DIME;
                else if (r_remaining >= AMT_W'(VAL_NICKEL) && w_nkl_nz)
                    w_pick = NICKEL;
                w_next_state = (w_pick == NONE) ? ERR : REQ;
            end
            REQ: begin
                if (w_ack)
                    w_next_state = (r_remaining == w_value) ? DONE : SELECT;
                else if (r_coin_req && r_tmo == TMO_W'(ACK_TMO - 1))
                    w_next_state = ERR;
            end
            DONE:    w_next_state = IDLE;
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (srst)
            w_next_state = IDLE;
    end

    // coin_req rises one cycle after entering REQ so the freshly registered coin_out is settled first.
    always_ff @(posedge clk or negedge hrst) begin
        if (!hrst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_tmo       <= '0;
            r_coin_req  <= 1'b0;
            r_coin_out  <= NONE;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_bal_ready <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_bal_ready <= (w_next_state == IDLE);
            r_coin_req  <= (r_state == REQ) && (w_next_state == REQ);
            r_done      <= (r_state == DONE) && !srst;
            r_err       <= (r_state == ERR) && !srst;
            r_tmo       <= (r_state == REQ && r_coin_req && !w_ack) ? r_tmo + TMO_W'(1) : '0;

            if (srst)
                r_remaining <= '0;
            else if (w_accept)
                r_remaining <= balance;
            else if (w_ack)
                r_remaining <= r_remaining - w_value;

            if (srst)
                r_coin_out <= NONE;
            else if (r_state == SELECT)
                r_coin_out <= w_pick;
            else if (r_state == REQ && w_next_state != REQ)
                r_coin_out <= NONE;
        end
    end

    assign bal_ready   = r_bal_ready;
    assign coin_req    = r_coin_req;
    assign coin_out    = r_coin_out;
    assign change_done = r_done;
    assign change_err  = r_err;
    assign remaining   = r_remaining;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// tb/tb_vm2002_change_dispenser.sv - table-driven scoreboard bench for vm2002_change_dispenser
module tb_vm2002_change_dispenser;
    import vm2002_common_pkg::*;

    localparam int ACK_TMO = 15;

    logic       clk = 1'b0;
    logic       hrst;
    logic       srst;
    logic       balance_valid;
    logic [7:0] balance;
    logic       bal_ready;
    logic       coin_req;
    coins_t     coin_out;
    logic       coin_ack;
    logic       reload;
    coins_t     reload_coin;
    logic [7:0] reload_count;
    logic       change_done;
    logic       change_err;
    logic [7:0] remaining;
    logic       low_change;

    always #5 clk = ~clk;

    vm2002_change_dispenser #(.ACK_TMO(ACK_TMO)) dut (
        .clk           (clk),
        .hrst          (hrst),
        .srst          (srst),
        .balance_valid (balance_valid),
        .balance       (balance),
        .bal_ready     (bal_ready),
        .coin_req      (coin_req),
        .coin_out      (coin_out),
        .coin_ack      (coin_ack),
        .reload        (reload),
        .reload_coin   (reload_coin),
        .reload_count  (reload_count),
        .change_done   (change_done),
        .change_err    (change_err),
        .remaining     (remaining),
        .low_change    (low_change)
    );

    typedef struct {
        int bal;
        bit ok;
        int rem;
        int nq;
        int nd;
        int nn;
        int lat;
    } vec_t;

    typedef struct {
        bit ok;
        int rem;
    } res_t;

    vec_t   vecs[12];
    coins_t exp_coins[$];
    res_t   exp_res[$];
    int     total = 0;
    int     bad   = 0;
    int     m_q   = 20;
    int     m_d   = 20;
    int     m_n   = 20;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_inv(input string tag);
        chk({tag, "_inv_qtr"},  int'(dut.u_inv.r_qtr),  m_q);
        chk({tag, "_inv_dime"}, int'(dut.u_inv.r_dime), m_d);
        chk({tag, "_inv_nkl"},  int'(dut.u_inv.r_nkl),  m_n);
        chk({tag, "_low_change"}, int'(low_change), int'(m_q == 0 || m_d == 0 || m_n == 0));
    endtask

    task automatic do_reload(input coins_t c, input int n);
        reload       = 1'b1;
        reload_coin  = c;
        reload_count = 8'(n);
        @(negedge clk);
        reload       = 1'b0;
        reload_coin  = NONE;
        reload_count = 8'd0;
        @(negedge clk);
    endtask

    // Hopper model lives here: it acks each request after a random delay and pops the expected coin.
    task automatic run_vec(input int i, input bit ack_en);
        vec_t v;
        res_t r;
        int   first_req;
        int   req_cyc;
        int   wt;
        bit   seen;
        string tag;
        v   = vecs[i];
        tag = $sformatf("vec%0d", i);
        if (ack_en) begin
            for (int k = 0; k < v.nq; k++) exp_coins.push_back(QUARTER);
            for (int k = 0; k < v.nd; k++) exp_coins.push_back(DIME);
            for (int k = 0; k < v.nn; k++) exp_coins.push_back(NICKEL);
        end
        r.ok  = v.ok;
        r.rem = v.rem;
        exp_res.push_back(r);
        chk({tag, "_bal_ready"}, int'(bal_ready), 1);
        balance       = 8'(v.bal);
        balance_valid = 1'b1;
        @(negedge clk);
        balance_valid = 1'b0;
        seen      = 1'b0;
        first_req = -1;
        req_cyc   = 0;
        wt        = $urandom_range(0, 3);
        for (int cyc = 1; cyc <= 600 && !seen; cyc++) begin
            @(negedge clk);
            if (coin_req && first_req < 0) first_req = cyc;
            if (coin_ack) begin
                coin_ack = 1'b0;
            end else if (coin_req) begin
                req_cyc++;
                if (!ack_en) begin
                    if (req_cyc == 1) chk({tag, "_tmo_coin"}, int'(coin_out), int'(QUARTER));
                end else if (wt == 0) begin
                    if (exp_coins.size() == 0)
                        chk({tag, "_unexpected_coin"}, int'(coin_out), int'(NONE));
                    else
                        chk({tag, "_coin"}, int'(coin_out), int'(exp_coins.pop_front()));
                    coin_ack = 1'b1;
                    wt = $urandom_range(0, 3);
                end else begin
                    wt--;
                end
            end
            if (change_done || change_err) begin
                seen = 1'b1;
                r = exp_res.pop_front();
                chk({tag, "_done"}, int'(change_done), int'(r.ok));
                chk({tag, "_err"},  int'(change_err),  int'(!r.ok));
                chk({tag, "_remaining"}, int'(remaining), r.rem);
                if (v.lat > 0) chk({tag, "_latency"}, cyc, v.lat);
            end
        end
        if (!seen) chk({tag, "_end_timeout"}, 0, 1);
        chk({tag, "_coins_left"}, exp_coins.size(), 0);
        exp_coins.delete();
        if (ack_en && (v.nq + v.nd + v.nn) > 0) chk({tag, "_first_req_cycle"}, first_req, 2);
        if (!ack_en) chk({tag, "_req_cycles"}, req_cyc, ACK_TMO);
        @(negedge clk);
        chk({tag, "_pulse_width"}, int'(change_done || change_err), 0);
        if (ack_en) begin
            m_q -= v.nq;
            m_d -= v.nd;
            m_n -= v.nn;
        end
        check_inv(tag);
    endtask

    initial begin
        bit got_req;
        vecs[0]  = '{40,  1'b1, 0,  1,  1,  1,  0};
        vecs[1]  = '{0,   1'b1, 0,  0,  0,  0,  1};
        vecs[2]  = '{37,  1'b0, 37, 0,  0,  0,  1};
        vecs[3]  = '{65,  1'b1, 0,  2,  1,  1,  0};
        vecs[4]  = '{250, 1'b1, 0,  10, 0,  0,  0};
        vecs[5]  = '{175, 1'b1, 0,  7,  0,  0,  0};
        vecs[6]  = '{30,  1'b1, 0,  0,  3,  0,  0};
        vecs[7]  = '{255, 1'b0, 15, 0,  15, 18, 0};
        vecs[8]  = '{30,  1'b0, 5,  1,  0,  0,  0};
        vecs[9]  = '{5,   1'b0, 5,  0,  0,  0,  2};
        vecs[10] = '{25,  1'b0, 25, 0,  0,  0,  0};
        vecs[11] = '{15,  1'b1, 0,  0,  1,  1,  0};

        hrst          = 1'b0;
        srst          = 1'b0;
        balance_valid = 1'b0;
        balance       = 8'd0;
        coin_ack      = 1'b0;
        reload        = 1'b0;
        reload_coin   = NONE;
        reload_count  = 8'd0;
        repeat (3) @(negedge clk);
        hrst = 1'b1;
        @(negedge clk);
        chk("rst_bal_ready", int'(bal_ready), 1);
        chk("rst_coin_req", int'(coin_req), 0);
        chk("rst_coin_out", int'(coin_out), int'(NONE));
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_done_err", int'(change_done || change_err), 0);
        check_inv("rst");

        for (int i = 0; i < 8; i++) run_vec(i, 1'b1);

        do_reload(QUARTER, 20);
        m_q += 20;
        check_inv("reload_qtr");
        for (int i = 8; i < 10; i++) run_vec(i, 1'b1);

        do_reload(DIME, 200);
        m_d = 200;
        check_inv("reload_dime");
        do_reload(DIME, 100);
        m_d = 255;
        check_inv("reload_dime_sat");
        do_reload(NONE, 50);
        check_inv("reload_none");
        do_reload(NICKEL, 20);
        m_n += 20;
        check_inv("reload_nkl");

        run_vec(10, 1'b0);

        balance       = 8'd40;
        balance_valid = 1'b1;
        @(negedge clk);
        balance_valid = 1'b0;
        reload        = 1'b1;
        reload_coin   = NICKEL;
        reload_count  = 8'd5;
        got_req       = 1'b0;
        for (int k = 0; k < 10 && !got_req; k++) begin
            @(negedge clk);
            if (coin_req) got_req = 1'b1;
        end
        chk("srst_req_seen", int'(got_req), 1);
        chk("srst_first_coin", int'(coin_out), int'(QUARTER));
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        chk("srst_req_dropped", int'(coin_req), 0);
        chk("srst_rem_before", int'(remaining), 15);
        srst = 1'b1;
        @(negedge clk);
        srst   = 1'b0;
        reload = 1'b0;
        reload_coin  = NONE;
        reload_count = 8'd0;
        chk("srst_bal_ready", int'(bal_ready), 1);
        chk("srst_remaining", int'(remaining), 0);
        chk("srst_coin_req", int'(coin_req), 0);
        chk("srst_coin_out", int'(coin_out), int'(NONE));
        @(negedge clk);
        chk("srst_no_pulse", int'(change_done || change_err), 0);
        m_q -= 1;
        check_inv("srst");

        run_vec(11, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
